// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Small instruction buffer: push/pop/flush, head driven straight from the storage flops.
module instr_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rptr_q, wptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  // The fetch credit rule guarantees a free slot for every accepted response.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    (push_i && !flush_i) |-> (count_q < CntW'(Depth)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid, and hands buffered
// words with their PC to the datapath; redirects flush the buffer and drop stale fetches.
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction_word,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  import fetch_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              discard_q, discard_d;
  logic              push, granted;
  logic [CntW-1:0]   fifo_count;
  logic [2*XLEN-1:0] head;

  // At most one request is outstanding, and only in StWait, so in StReq the credit
  // check reduces to the buffer occupancy.
  assign imem_req  = (state_q == StReq) && (fifo_count < CntW'(FIFO_DEPTH));
  assign imem_addr = imem_req ? pc_q : '0;
  assign granted   = imem_req & imem_gnt;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    push      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (granted) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          push      = !discard_q;
          discard_d = 1'b0;
          state_d   = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything; a fetch still in flight is marked for discard.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
      push = 1'b0;
      if (granted || (state_q == StWait && !imem_rvalid)) begin
        discard_d = 1'b1;
        state_d   = StWait;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  instr_fifo #(
    .Width(2 * XLEN),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(redirect_valid),
    .push_i (push),
    .data_i ({imem_rdata, req_pc_q}),
    .pop_i  (instr_valid & instr_ready),
    .valid_o(instr_valid),
    .data_o (head),
    .count_o(fifo_count)
  );

  assign instruction_word = head[2*XLEN-1:XLEN];
  assign instr_pc         = head[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder plus an in-order delivery model.
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0, rst = 1'b0;
  logic imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instruction_word, instr_pc;

  logic imem_gnt_w = 1'b0, imem_rvalid_w = 1'b0;
  logic [31:0] imem_rdata_w = '0;
  logic imem_req_w, instr_valid_w;
  logic [31:0] imem_addr_w, instruction_word_w, instr_pc_w;

  int n_cmp = 0, n_err = 0;

  // Model state
  ent_t exp_q[$];
  int epoch = 0;
  logic [31:0] m_fetch_pc = '0;
  bit m_out = 0;
  // Responder state
  bit pend = 0;
  logic [31:0] pend_addr = '0;
  int pend_epoch = 0, pend_wait = 0, stall_left = 0, lat_fix = 0;
  bit rand_stall = 0;
  logic [31:0] salt = '0;
  logic [31:0] gnt_log[$];
  ent_t del_log[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction_word(instruction_word),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_gnt(imem_gnt_w), .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .instruction_word(instruction_word_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0010_0013;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One clock of stimulus: check DUT against the model, then drive the next edge.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit resp;
    logic [31:0] raddr;
    int repoch;
    ent_t e;
    resp = 0; raddr = '0; repoch = 0;
    @(negedge clk);
    n_cmp++;
    if (instr_valid !== (exp_q.size() != 0)) begin
      n_err++; $display("FAIL valid: got %b want %b", instr_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (instruction_word !== exp_q[0].word || instr_pc !== exp_q[0].pc) begin
        n_err++;
        $display("FAIL head: got %h/%h want %h/%h", instruction_word, instr_pc,
                 exp_q[0].word, exp_q[0].pc);
      end
    end
    n_cmp++;
    if (imem_req !== (!m_out && exp_q.size() < DEPTH)) begin
      n_err++; $display("FAIL req: got %b want %b", imem_req, !m_out && exp_q.size() < DEPTH);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
        resp = 1; raddr = pend_addr; repoch = pend_epoch; pend = 0;
      end else pend_wait--;
    end else if (imem_req === 1'b1) begin
      n_cmp++;
      if (imem_addr !== m_fetch_pc) begin
        n_err++; $display("FAIL addr: got %h want %h", imem_addr, m_fetch_pc);
      end
      if (stall_left > 0) stall_left--;
      else if (!(rand_stall && $urandom_range(0, 2) == 0)) begin
        imem_gnt = 1'b1; pend = 1; pend_addr = imem_addr; pend_epoch = epoch;
        pend_wait = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
        gnt_log.push_back(imem_addr);
        m_fetch_pc += 32'd4; m_out = 1;
      end
    end
    if (resp) m_out = 0;
    instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    if (rdy && exp_q.size() != 0 && !redir) del_log.push_back(exp_q.pop_front());
    if (redir) begin
      exp_q.delete(); epoch++; m_fetch_pc = {rpc[31:2], 2'b00};
    end
    if (resp && !redir && repoch == epoch) begin
      e.word = mem_word(raddr); e.pc = raddr; exp_q.push_back(e);
    end
  endtask

  task automatic apply_reset(input bit keep_pend);
    rst = 1'b0; imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; redirect_valid = 0;
    imem_gnt_w = 0; imem_rvalid_w = 0;
    repeat (3) @(negedge clk);
    exp_q.delete(); m_out = 0; epoch++; m_fetch_pc = 32'h0; stall_left = 0;
    if (keep_pend) pend_wait = 0; else pend = 0;
    gnt_log.delete(); del_log.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instruction_word !== 32'h0) begin n_err++; $display("FAIL rst_word: got %h want 0", instruction_word); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    n_cmp++;
    if ({imem_req_w, imem_addr_w, instr_valid_w} !== '0) begin
      n_err++; $display("FAIL rst_wrap: got %b/%h/%b want 0", imem_req_w, imem_addr_w, instr_valid_w);
    end
  endtask

  task automatic test_first_fetch();
    apply_reset(0); lat_fix = 0; rand_stall = 0;
    repeat (8) cycle(1, 0, 32'h0);
    n_cmp++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4) begin
      n_err++; $display("FAIL first_addrs: got %p want 0,4", gnt_log);
    end
    n_cmp++;
    if (del_log.size() < 2 || del_log[0] !== {32'h0010_0093, 32'h0}
        || del_log[1] !== {32'h0010_0013, 32'h4}) begin
      n_err++; $display("FAIL first_words: got %p want 00100093@0,00100013@4", del_log);
    end
  endtask

  task automatic test_backpressure();
    apply_reset(0); lat_fix = 0;
    repeat (12) cycle(0, 0, 32'h0);
    n_cmp++; if (gnt_log.size() != 2) begin n_err++; $display("FAIL bp_grants: got %0d want 2", gnt_log.size()); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b want 0", imem_req); end
    n_cmp++;
    if (instruction_word !== 32'h0010_0093 || instr_pc !== 32'h0) begin
      n_err++; $display("FAIL bp_head: got %h/%h want 00100093/0", instruction_word, instr_pc);
    end
    for (int i = 0; i < 40 && !(del_log.size() >= 3 && gnt_log.size() >= 4); i++) cycle(1, 0, 32'h0);
    n_cmp++;
    if (del_log.size() < 3 || del_log[0].pc !== 32'h0 || del_log[1].pc !== 32'h4
        || del_log[2].pc !== 32'h8) begin
      n_err++; $display("FAIL bp_order: got %p want pcs 0,4,8", del_log);
    end
    n_cmp++;
    if (gnt_log.size() < 4 || gnt_log[3] !== 32'hC) begin
      n_err++; $display("FAIL bp_resume: got %p want 4th addr c", gnt_log);
    end
  endtask

  task automatic test_gnt_stall();
    int seen;
    seen = 0;
    apply_reset(0); lat_fix = 0;
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) cycle(1, 0, 32'h0);
    stall_left = 3;
    for (int i = 0; i < 20 && gnt_log.size() < 3; i++) begin
      cycle(1, 0, 32'h0);
      if (imem_req === 1'b1 && imem_addr === 32'h8) seen++;
    end
    n_cmp++; if (seen != 4) begin n_err++; $display("FAIL stall_hold: got %0d want 4", seen); end
    for (int i = 0; i < 20 && gnt_log.size() < 4; i++) cycle(1, 0, 32'h0);
    n_cmp++;
    if (gnt_log.size() < 4 || gnt_log[2] !== 32'h8 || gnt_log[3] !== 32'hC) begin
      n_err++; $display("FAIL stall_addrs: got %p want 3rd 8, 4th c", gnt_log);
    end
  endtask

  task automatic test_redirect();
    int n0;
    apply_reset(0); lat_fix = 1;
    for (int i = 0; i < 20 && gnt_log.size() < 3; i++) cycle(1, 0, 32'h0);
    cycle(1, 1, 32'h103);
    n0 = del_log.size();
    @(posedge clk); #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
    for (int i = 0; i < 30 && (gnt_log.size() < 4 || del_log.size() <= n0); i++) cycle(1, 0, 32'h0);
    n_cmp++;
    if (gnt_log.size() < 4 || gnt_log[3] !== 32'h100) begin
      n_err++; $display("FAIL redir_addr: got %p want 4th 100", gnt_log);
    end
    n_cmp++;
    if (del_log.size() <= n0 || del_log[n0].pc !== 32'h100) begin
      n_err++; $display("FAIL redir_deliver: got %p want next pc 100", del_log);
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] alog[$];
    logic [31:0] plog[$];
    logic [31:0] wlog[$];
    bit pw;
    logic [31:0] pa;
    pw = 0; pa = '0;
    apply_reset(0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (instr_valid_w === 1'b1) begin plog.push_back(instr_pc_w); wlog.push_back(instruction_word_w); end
      imem_gnt_w = 0; imem_rvalid_w = 0;
      if (pw) begin
        imem_rvalid_w = 1; imem_rdata_w = ~pa; pw = 0;
      end else if (imem_req_w === 1'b1) begin
        alog.push_back(imem_addr_w); imem_gnt_w = 1; pw = 1; pa = imem_addr_w;
      end
    end
    imem_gnt_w = 0; imem_rvalid_w = 0;
    n_cmp++;
    if (alog.size() < 2 || alog[0] !== 32'hFFFF_FFFC || alog[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: got %p want fffffffc,0", alog);
    end
    n_cmp++;
    if (plog.size() < 2 || plog[0] !== 32'hFFFF_FFFC || wlog[0] !== 32'h3
        || plog[1] !== 32'h0 || wlog[1] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_deliver: got %p/%p want fffffffc,0", plog, wlog);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 0;
    apply_reset(0); lat_fix = 2;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(0, 0, 32'h0);
      found = m_out && exp_q.size() >= 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL async_setup: got 0 want 1"); end
    @(posedge clk); #2;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL async_pre: got %b want 1", instr_valid); end
    rst = 1'b0; #1;
    n_cmp++;
    if ({imem_req, imem_addr, instr_valid, instruction_word, instr_pc} !== '0) begin
      n_err++;
      $display("FAIL async_clear: got %b/%h/%b/%h/%h want 0", imem_req, imem_addr, instr_valid,
               instruction_word, instr_pc);
    end
    apply_reset(1); lat_fix = 0;
    repeat (10) cycle(1, 0, 32'h0);
    n_cmp++;
    if (gnt_log.size() < 1 || gnt_log[0] !== 32'h0) begin
      n_err++; $display("FAIL async_refetch: got %p want 0", gnt_log);
    end
    n_cmp++;
    if (del_log.size() < 1 || del_log[0] !== {32'h0010_0093, 32'h0}) begin
      n_err++; $display("FAIL async_first: got %p want 00100093@0", del_log);
    end
  endtask

  task automatic test_random();
    apply_reset(0); lat_fix = -1; rand_stall = 1;
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom);
    rand_stall = 0;
    n_cmp++; if (del_log.size() < 50) begin n_err++; $display("FAIL rand_progress: got %0d want >=50", del_log.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    salt = $urandom;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_reset_pc_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply end of the DataPath `instruction_word` interface.
- Owns the PC and issues read requests to instruction memory over a req/gnt/rvalid bus.
- Buffers returned words in a small FIFO and presents them, with their PC, to the datapath over a valid/ready handshake.
- Accepts branch/jump redirects from the datapath, flushing stale fetches.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  XLEN  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  read data.
- instruction_word  out  XLEN  instruction at FIFO head.
- instr_pc  out  XLEN  PC of instruction_word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  datapath consumes head when high with instr_valid.
- redirect_valid  in  1  PC redirect request.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, forced 00.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; FIFO empty; discard flag clear; state IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instruction_word=0, instr_pc=0.
- IDLE: next clock after rst release, go to REQ.
- REQ:
  - imem_req=1 only when (fifo_count + outstanding) < FIFO_DEPTH; otherwise imem_req=0 and stay in REQ.
  - While imem_req=1 and no gnt: imem_addr=pc, held stable.
  - On imem_gnt: latch req_pc=pc, pc<=pc+4 (mod 2^XLEN, 0xFFFF_FFFC wraps to 0), go to WAIT.
- WAIT:
  - imem_req=0; at most one outstanding request.
  - On imem_rvalid, if discard flag is clear: push {imem_rdata, req_pc}.
  - On imem_rvalid, if discard flag is set: drop the data and clear the flag.
  - Go to REQ on the same edge; a new request may be asserted the next cycle.
- Output:
  - instr_valid = FIFO non-empty; instruction_word/instr_pc = head entry.
  - Registered FIFO: rvalid in cycle N gives instr_valid in cycle N+1.
  - Pop on instr_valid & instr_ready.
  - Head is held stable while valid & !ready.
  - Simultaneous push and pop is legal and preserves count.
  - The credit rule makes push into a full FIFO impossible; assert this.
- Redirect (any state, highest priority):
  - pc<=redirect_pc & ~3; FIFO flushed, so instr_valid=0 next cycle.
  - A pop in the same cycle is ignored.
  - In WAIT without same-cycle rvalid, or in REQ with same-cycle gnt: set discard flag so exactly one later response is dropped.
  - In WAIT with same-cycle rvalid: the data is dropped, no flag is set.
  - Next state REQ, or WAIT if a granted request is still outstanding.
  - The first request after redirect uses the new pc.
- No ready-to-valid combinational path. imem_req depends only on registered state.
- Reset mid-operation: all state clears immediately. An in-flight rvalid arriving after release is ignored, because the state is not WAIT.

Decomposition:
- Shared package `fetch_pkg`:
  - XLEN, RESET_PC default, ALIGN_MASK, NOP_INSTR = 32'h0000_0013.
  - Fetch state enum {IDLE, REQ, WAIT}.
- One sub-module: `instr_fifo`.
  - Parameterised width and depth; push/pop/flush; count output; head registered outputs.
  - Same clk/rst convention.

Test Plan:
1. Hold rst=0 for 10 cycles: all outputs 0. Release, with memory giving gnt the same cycle and rvalid one cycle later, returning 32'h00100093 at 0x0 and 32'h00100013 at 0x4 -> imem_addr sequence 0x0, 0x4; instr_valid with word 32'h00100093/pc 0x0, then 32'h00100013/pc 0x4.
2. instr_ready=0 -> after 2 words buffered, imem_req stays 0 and head is stable. Raise ready -> words pop in order 0x0, 0x4, 0x8; fetch resumes at 0xC.
3. Withhold imem_gnt for 3 cycles -> imem_req=1 and imem_addr=0x8 constant throughout; pc advances only after gnt.
4. redirect_valid with redirect_pc=0x103 while in WAIT for 0x8 -> instr_valid=0 next cycle; the 0x8 response is dropped; next imem_addr=0x100; first delivered instr_pc=0x100.
5. RESET_PC=0xFFFF_FFFC -> first imem_addr=0xFFFF_FFFC, second 0x0000_0000.
6. Drive rst=0 asynchronously mid-WAIT with instr_valid=1 -> outputs zero before the next clock edge. A late rvalid after release is not delivered; the first fetch is RESET_PC.
